// File: rtl/ym3016_serial_tx.sv
// YM3016 serial DAC transmitter: encodes 16-bit signed L/R pairs to 10-bit mantissa + 3-bit
// exponent floating point and serialises them LSB first in a 32-slot frame.
module ym3016_serial_tx #(
  parameter int unsigned CLK_DIV = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] pcm_l,
  input  logic [15:0] pcm_r,
  input  logic        pcm_valid,
  output logic        pcm_ready,
  output logic        dac_clk,
  output logic        dac_so,
  output logic        dac_sh1,
  output logic        dac_sh2,
  output logic        frame_start,
  output logic        underrun
);

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  // Encoding of a zero sample: e=1, offset-binary mantissa 0x200.
  localparam logic [12:0] ENC_ZERO = {3'd1, 10'h200};

  // Returns {e[2:0], t[9:0]}: smallest exponent whose shifted sample fits 10-bit signed.
  function automatic logic [12:0] f_encode(input logic [15:0] sample);
    logic signed [15:0] v_shifted;
    logic [2:0]         v_exp;
    v_exp = 3'd7;
    for (int k = 6; k >= 0; k--) begin
      v_shifted = $signed(sample) >>> k;
      if (v_shifted >= -16'sd512 && v_shifted <= 16'sd511) v_exp = 3'(k + 1);
    end
    v_shifted = $signed(sample) >>> (v_exp - 3'd1);
    return {v_exp, v_shifted[9:0] ^ 10'h200};
  endfunction

  logic [7:0]  r_div;
  logic [4:0]  r_slot;
  logic        r_dac_clk;
  logic        r_so;
  logic        r_sh1;
  logic        r_sh2;
  logic        r_frame_start;
  logic        r_underrun;
  logic        r_ready;
  logic [15:0] r_hold_l;
  logic [15:0] r_hold_r;
  logic [12:0] r_cur_l;
  logic [12:0] r_cur_r;

  logic        w_div_wrap;
  logic        w_launch;
  logic        w_load;
  logic        w_accept;
  logic [4:0]  w_slot_next;
  logic [12:0] w_enc_l;
  logic [12:0] w_enc_r;
  logic [12:0] w_cur_l_next;
  logic [12:0] w_cur_r_next;
  logic [15:0] w_word;

  // NOTE: every signal written here gets a value on every path, so no latch can be inferred.
  always_comb begin
    w_div_wrap   = (r_div == DIV_LAST);
    w_launch     = w_div_wrap && !r_dac_clk;
    w_slot_next  = r_slot + 5'd1;
    w_load       = w_launch && (r_slot == 5'd31);
    w_accept     = pcm_valid && r_ready;
    w_enc_l      = f_encode(r_hold_l);
    w_enc_r      = f_encode(r_hold_r);
    // An empty holding register on load means the previous pair is repeated.
    w_cur_l_next = (w_load && !r_ready) ? w_enc_l : r_cur_l;
    w_cur_r_next = (w_load && !r_ready) ? w_enc_r : r_cur_r;
    w_word       = w_slot_next[4] ? {w_cur_r_next, 3'b000} : {w_cur_l_next, 3'b000};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div         <= '0;
      r_slot        <= 5'd31;
      r_dac_clk     <= 1'b0;
      r_so          <= 1'b0;
      r_sh1         <= 1'b0;
      r_sh2         <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_ready       <= 1'b1;
      r_hold_l      <= '0;
      r_hold_r      <= '0;
      r_cur_l       <= ENC_ZERO;
      r_cur_r       <= ENC_ZERO;
    end else begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;

      // A same-cycle accept wins over the load's release, keeping the holding register full.
      if (w_accept) begin
        r_hold_l <= pcm_l;
        r_hold_r <= pcm_r;
        r_ready  <= 1'b0;
      end else if (w_load && !r_ready) begin
        r_ready  <= 1'b1;
      end

      if (!enable) begin
        r_div     <= '0;
        r_slot    <= 5'd31;
        r_dac_clk <= 1'b0;
        r_so      <= 1'b0;
        r_sh1     <= 1'b0;
        r_sh2     <= 1'b0;
      end else if (w_div_wrap) begin
        r_div     <= '0;
        r_dac_clk <= ~r_dac_clk;
        if (w_launch) begin
          r_slot <= w_slot_next;
          r_so   <= w_word[w_slot_next[3:0]];
          r_sh1  <= (w_slot_next >= 5'd13) && (w_slot_next <= 5'd15);
          r_sh2  <= (w_slot_next >= 5'd29);
          if (w_load) begin
            r_frame_start <= 1'b1;
            r_underrun    <= r_ready;
            r_cur_l       <= w_cur_l_next;
            r_cur_r       <= w_cur_r_next;
          end
        end
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

  assign pcm_ready   = r_ready;
  assign dac_clk     = r_dac_clk;
  assign dac_so      = r_so;
  assign dac_sh1     = r_sh1;
  assign dac_sh2     = r_sh2;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_ym3016_serial_tx.sv
// Bench for ym3016_serial_tx: a falling-edge receiver rebuilds each frame and compares it
// against an arithmetic encoder applied to the pairs tracked in a FIFO model of the handshake.
module tb_ym3016_serial_tx;

  localparam int CLK_DIV = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] pcm_l;
  logic [15:0] pcm_r;
  logic        pcm_valid;
  logic        pcm_ready;
  logic        dac_clk;
  logic        dac_so;
  logic        dac_sh1;
  logic        dac_sh2;
  logic        frame_start;
  logic        underrun;

  ym3016_serial_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pcm_l       (pcm_l),
    .pcm_r       (pcm_r),
    .pcm_valid   (pcm_valid),
    .pcm_ready   (pcm_ready),
    .dac_clk     (dac_clk),
    .dac_so      (dac_so),
    .dac_sh1     (dac_sh1),
    .dac_sh2     (dac_sh2),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] q_l[$];
  logic [15:0] q_r[$];
  logic [15:0] last_l, last_r, exp_l, exp_r;
  int          rx_idx;
  logic [31:0] rx_bits;
  logic        prev_dclk;
  int          frames_done;
  logic        en_used, rst_used, acc_seen, saw_fs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Floor-divide by 2^(e-1) for e=1..7, keep the smallest e that lands in -512..511.
  function automatic logic [15:0] ref_word(input logic [15:0] raw);
    int s, d, v, e_sel, v_sel, t;
    s     = int'($signed(raw));
    e_sel = 7;
    v_sel = 0;
    for (int e = 7; e >= 1; e--) begin
      d = 1 << (e - 1);
      v = (s >= 0) ? s / d : -((-s + d - 1) / d);
      if (v >= -512 && v <= 511) begin
        e_sel = e;
        v_sel = v;
      end
    end
    t = v_sel + 512;
    return {e_sel[2:0], t[9:0], 3'b000};
  endfunction

  task automatic monitor();
    if (rst_used) begin
      q_l.delete();
      q_r.delete();
      last_l    = '0;
      last_r    = '0;
      rx_idx    = -1;
      prev_dclk = 1'b0;
      saw_fs    = 1'b0;
      return;
    end
    saw_fs = (frame_start === 1'b1);
    if (saw_fs) begin
      check("underrun_at_load", 32'(underrun), 32'(q_l.size() == 0));
      if (rx_idx >= 0) check("frame_length", 32'(rx_idx), 32'd32);
      if (q_l.size() > 0) begin
        last_l = q_l.pop_front();
        last_r = q_r.pop_front();
      end
      exp_l  = last_l;
      exp_r  = last_r;
      rx_idx = 0;
    end else begin
      check("underrun_idle", 32'(underrun), 32'd0);
    end
    if (!en_used) begin
      check("idle_outputs", 32'({dac_clk, dac_so, dac_sh1, dac_sh2}), 32'd0);
      rx_idx = -1;
    end else if (prev_dclk === 1'b1 && dac_clk === 1'b0 && rx_idx >= 0 && rx_idx < 32) begin
      rx_bits[rx_idx] = dac_so;
      check("sh_strobes", 32'({dac_sh1, dac_sh2}),
            32'({(rx_idx >= 13 && rx_idx <= 15), (rx_idx >= 29)}));
      rx_idx++;
      if (rx_idx == 32) begin
        check("left_word", 32'(rx_bits[15:0]), 32'(ref_word(exp_l)));
        check("right_word", 32'(rx_bits[31:16]), 32'(ref_word(exp_r)));
        frames_done++;
      end
    end
    if (acc_seen) begin
      q_l.push_back(pcm_l);
      q_r.push_back(pcm_r);
    end
    check("pcm_ready", 32'(pcm_ready), 32'(q_l.size() == 0));
    prev_dclk = dac_clk;
  endtask

  task automatic step();
    acc_seen = pcm_valid && (pcm_ready === 1'b1);
    en_used  = enable;
    rst_used = reset;
    @(posedge clk);
    @(negedge clk);
    monitor();
    if (acc_seen) pcm_valid = 1'b0;
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    int n;
    pcm_l     = l;
    pcm_r     = r;
    pcm_valid = 1'b1;
    n = 0;
    while (pcm_valid && n < 2000) begin
      step();
      n++;
    end
    check("accept_in_time", 32'(pcm_valid), 32'd0);
    pcm_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 5000) begin
      step();
      n++;
    end
    check("frames_in_time", 32'(frames_done >= target), 32'd1);
  endtask

  task automatic steps_to_fs(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!saw_fs && n < 1000);
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    enable      = 1'b0;
    pcm_valid   = 1'b0;
    pcm_l       = '0;
    pcm_r       = '0;
    rx_idx      = -1;
    rx_bits     = '0;
    prev_dclk   = 1'b0;
    frames_done = 0;
    last_l      = '0;
    last_r      = '0;
    exp_l       = '0;
    exp_r       = '0;
    saw_fs      = 1'b0;
    repeat (3) step();
    check("reset_outputs",
          32'({dac_clk, dac_so, dac_sh1, dac_sh2, frame_start, underrun, pcm_ready}), 32'b0000001);

    // First frame with nothing offered: first rise after CLK_DIV clocks, underrun on load.
    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= CLK_DIV; i++) begin
      step();
      check("first_rise", 32'(dac_clk), 32'(i == CLK_DIV));
    end
    check("first_load_flags", 32'({frame_start, underrun}), 32'b11);

    // Encoding corner values and the mid-frame handshake pair.
    offer(16'h01FF, 16'h0200);
    offer(16'h7FFF, 16'h8000);
    offer(16'hFE00, 16'hFDFF);
    offer(16'h1234, 16'hEDCC);
    wait_frames(frames_done + 2);

    // Accept landing on the exact load cycle.
    steps_to_fs(n);
    repeat (32 * 2 * CLK_DIV - 1) step();
    pcm_l     = 16'h4C2D;
    pcm_r     = 16'hB3D2;
    pcm_valid = 1'b1;
    step();
    check("accept_at_load", 32'({frame_start, acc_seen}), 32'b11);
    pcm_valid = 1'b0;
    wait_frames(frames_done + 2);

    // Drop enable mid-frame with a pair pending, then resume.
    steps_to_fs(n);
    offer(16'h0ABC, 16'hF123);
    n = 0;
    while (rx_idx < 20 && n < 500) begin
      step();
      n++;
    end
    check("reached_slot20", 32'(rx_idx), 32'd20);
    enable = 1'b0;
    repeat (10) step();
    enable = 1'b1;
    steps_to_fs(n);
    check("reenable_delay", 32'(n), 32'(CLK_DIV));
    wait_frames(frames_done + 1);

    // Reset mid-frame discards the partial frame.
    n = 0;
    while (rx_idx < 10 && n < 500) begin
      step();
      n++;
    end
    reset = 1'b1;
    step();
    check("midframe_reset",
          32'({dac_clk, dac_so, dac_sh1, dac_sh2, frame_start, underrun, pcm_ready}), 32'b0000001);
    reset = 1'b0;
    steps_to_fs(n);
    check("post_reset_delay", 32'(n), 32'(CLK_DIV));

    // Random pairs with random gaps, some long enough to underrun.
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 260)) step();
      offer(16'($urandom), 16'($urandom));
    end
    wait_frames(frames_done + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ym3016_serial_tx.md
Name: ym3016_serial_tx

Overview:
- Transmitter for the YM3016 serial DAC stream: the same format the board's ym3016 decoder receives from the YM2610.
- Takes 16-bit signed left/right PCM pairs and converts each to YM3016 floating point: 10-bit mantissa plus 3-bit exponent.
- Serialises each pair onto dac_clk/dac_so/dac_sh1/dac_sh2, with bit clock generated internally from clk.
- Used for loopback self-test of the DAC capture/SPDIF path, and to drive an external YM3016 when the FPGA synthesises audio.

Parameters:
- CLK_DIV, 3: clk cycles per dac_clk half-period (bit period = 2*CLK_DIV clk cycles); legal range 1..255.

Ports:
- clk  input  1  system clock (clk_24m domain)
- reset  input  1  synchronous, active-high reset
- enable  input  1  run serialiser; when low, stream idles
- pcm_l  input  16  left sample, two's complement
- pcm_r  input  16  right sample, two's complement
- pcm_valid  input  1  sample pair offered
- pcm_ready  output  1  holding register empty; pair accepted when pcm_valid && pcm_ready
- dac_clk  output  1  serial bit clock
- dac_so  output  1  serial data
- dac_sh1  output  1  left-channel latch strobe
- dac_sh2  output  1  right-channel latch strobe
- frame_start  output  1  one-clk pulse when slot 0 is launched
- underrun  output  1  one-clk pulse when a frame starts with no new pair (previous pair repeated)

Behaviour:
- Reset values:
  - dac_clk=0, dac_so=0, dac_sh1=0, dac_sh2=0, frame_start=0, underrun=0, pcm_ready=1.
  - Holding and current pair both cleared to 0; divider=0; slot=31, so the first launched slot is 0.
- Divider:
  - Counts 0..CLK_DIV-1 while enable=1.
  - On wrap, dac_clk toggles.
  - A 0->1 toggle is a launch edge: slot advances mod 32 and dac_so/sh1/sh2 update in the same clk cycle.
  - The receiver samples on dac_clk falling edge, so data is stable for CLK_DIV clk cycles before sampling.
- Frame: 32 slots.
  - Slots 0-15 carry left, slots 16-31 carry right.
  - Per 16-slot word, LSB first:
    - 3 zero bits.
    - Transmitted mantissa bits t0..t9.
    - Exponent bits e0..e2.
  - dac_sh1=1 during slots 13-15, else 0. dac_sh2=1 during slots 29-31, else 0.
- Encoding, combinational on the holding pair, captured into the current frame at frame load:
  - Exponent e is the smallest value in 1..7 such that sample>>>(e-1) fits in 10-bit signed (-512..511). e=7 always fits.
  - m = (sample>>>(e-1))[9:0], arithmetic shift with truncation toward -inf.
  - Transmitted mantissa t = m ^ 10'h200 (offset binary).
- Frame load:
  - Occurs on the launch edge that moves slot 31->0.
  - If the holding register is full: copy the encoded pair into the current frame, set pcm_ready=1, pulse frame_start.
  - If the holding register is empty: re-send the previous pair, pulse underrun and frame_start.
- Handshake:
  - An accept sets pcm_ready=0 on the next cycle.
  - If an accept and a frame load occur in the same cycle, the load takes the old holding contents, the new pair enters holding, and pcm_ready stays 0.
  - Latency: accepted pair appears starting at the next frame load (max 32 bit periods + 1 clk).
- enable=0:
  - Divider clears; slot returns to 31; dac_clk, dac_so, dac_sh1, dac_sh2 all drive 0.
  - The handshake still operates.
  - Re-enable starts a full frame from slot 0 after CLK_DIV clk cycles.
- reset mid-frame: all outputs return to reset values on the next clk; the partial frame is discarded.

Test Plan:
- After reset, enable=1, CLK_DIV=3, no samples offered -> first dac_clk rise 3 clks after enable; frame_start and underrun pulse together; left word serialises as 000, t=0x200 LSB first, e=1 (e0=1); dac_sh1 high in slots 13-15 only.
- Encode check via decoded slots: 0x01FF -> e=1, t=0x3FF; 0x0200 -> e=2, t=0x300; 0x7FFF -> e=7, t=0x3FF; 0x8000 -> e=7, t=0x000; 0xFE00 -> e=1, t=0x000; 0xFDFF -> e=2, t=0x0FF.
- Handshake: offer L=0x1234, R=0xEDCC mid-frame -> pcm_ready drops next clk; pair appears from next slot 0; pcm_ready rises at that load; no underrun pulse.
- Simultaneous accept and frame load -> old holding pair transmitted, new pair transmitted in the following frame, pcm_ready stays 0 across the boundary.
- Drop enable at slot 20, re-raise 10 clks later -> outputs drive 0 while enable is low; next frame_start begins at slot 0; the pending pair is not lost.
- Loopback into the board's ym3016 decoder with dac_clk inverted to match its sampling edge -> the decoded left/right output matches the exponent/mantissa reconstruction of each sent pair for 8 consecutive frames.
